// File: rtl/mem_pkg.sv
// Shared encodings and the alignment rule for the load/store initiator.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RMW_READ = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Size 2'b11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis_s;
        case (size)
            SZ_BYTE: mis_s = 1'b0;
            SZ_HALF: mis_s = addr_lo[0];
            default: mis_s = (addr_lo != 2'b00);
        endcase
        return mis_s;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: load extraction/extension and sub-word store merge.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed lane and extend it to a full word.
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        load_data = 32'h0000_0000;
        case (addr_lo)
            2'b00:   byte_s = word[7:0];
            2'b01:   byte_s = word[15:8];
            2'b10:   byte_s = word[23:16];
            2'b11:   byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
            SZ_HALF: load_data = {{16{sign_ext & half_s[15]}}, half_s};
            default: load_data = word;
        endcase
    end

    // Replace the target lane of the old word with right-aligned store data.
    always_comb begin
        merge_data = word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'b00:   merge_data[7:0]   = wdata[7:0];
                    2'b01:   merge_data[15:8]  = wdata[7:0];
                    2'b10:   merge_data[23:16] = wdata[7:0];
                    2'b11:   merge_data[31:24] = wdata[7:0];
                    default: merge_data        = word;
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    merge_data[31:16] = wdata[15:0];
                end else begin
                    merge_data[15:0] = wdata[15:0];
                end
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle load/store initiator for a word-only data memory; sub-word stores
// are performed as read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    output logic [31:0]       rdata,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [31:0]       WriteData,
    input  logic [31:0]       ReadData
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              is_store_q;
    logic              sign_ext_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;
    logic [31:0]       load_data_s;
    logic [31:0]       merge_data_s;
    logic              mem_read_s;
    logic              mem_write_s;
    logic              sub_word_s;
    logic              accept_s;

    assign accept_s   = (state_q == ST_IDLE) && req;
    assign sub_word_s = (size_q == SZ_BYTE) || (size_q == SZ_HALF);

    mem_lane_align u_align (
        .word       (ReadData),
        .addr_lo    (addr_q[1:0]),
        .size       (size_q),
        .sign_ext   (sign_ext_q),
        .wdata      (wdata_q),
        .load_data  (load_data_s),
        .merge_data (merge_data_s)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; req only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (is_misaligned(size, addr[1:0])) begin
                    state_d = ST_DONE;
                end else if (!is_store) begin
                    state_d = ST_LOAD;
                end else if ((size == SZ_BYTE) || (size == SZ_HALF)) begin
                    state_d = ST_RMW_READ;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_LOAD:     state_d = ST_DONE;
            ST_RMW_READ: state_d = ST_WRITE;
            ST_WRITE:    state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Capture the request fields when an access is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= {ADDR_W{1'b0}};
            size_q     <= 2'b00;
            is_store_q <= 1'b0;
            sign_ext_q <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            err_q      <= 1'b0;
        end else if (accept_s) begin
            addr_q     <= addr;
            size_q     <= size;
            is_store_q <= is_store;
            sign_ext_q <= sign_ext;
            wdata_q    <= wdata;
            err_q      <= is_misaligned(size, addr[1:0]);
        end else begin
            addr_q     <= addr_q;
            size_q     <= size_q;
            is_store_q <= is_store_q;
            sign_ext_q <= sign_ext_q;
            wdata_q    <= wdata_q;
            err_q      <= err_q;
        end
    end

    // Merged word for the write half of a read-modify-write.
    always_ff @(posedge clock) begin
        if (reset) begin
            merge_q <= 32'h0000_0000;
        end else if (state_q == ST_RMW_READ) begin
            merge_q <= merge_data_s;
        end else begin
            merge_q <= merge_q;
        end
    end

    // Load result, held until the next completed load.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= 32'h0000_0000;
        end else if ((state_q == ST_LOAD) && !is_store_q) begin
            rdata_q <= load_data_s;
        end else begin
            rdata_q <= rdata_q;
        end
    end

    // Memory bus decode; reset gates MemWrite in the same cycle so an aborted
    // store never reaches memory, and an idle bus carries zeros.
    always_comb begin
        mem_read_s  = (state_q == ST_LOAD) || (state_q == ST_RMW_READ);
        mem_write_s = (state_q == ST_WRITE) && !reset;
        MemRead     = mem_read_s;
        MemWrite    = mem_write_s;
        if (mem_read_s || mem_write_s) begin
            Address = {addr_q[ADDR_W-1:2], 2'b00};
        end else begin
            Address = {ADDR_W{1'b0}};
        end
        if (!mem_write_s) begin
            WriteData = 32'h0000_0000;
        end else if (sub_word_s) begin
            WriteData = merge_q;
        end else begin
            WriteData = wdata_q;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign misaligned = (state_q == ST_DONE) && err_q;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit against a byte-level memory model.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        is_store;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic [31:0] rdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        load_init;
    logic [31:0] exp_rdata;
    logic [31:0] last_wd;
    int          passed = 0;
    int          total  = 0;

    always #5 clock = ~clock;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .is_store   (is_store),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned),
        .rdata      (rdata),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .WriteData  (WriteData),
        .ReadData   (ReadData)
    );

    assign ReadData = mem[Address[7:2]];

    always @(posedge clock) begin
        if (load_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
        end else if (MemWrite) begin
            mem[Address[7:2]] <= WriteData;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_quiet_bus(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_mis"}, misaligned, 1'b0);
        check({tag, "_rd"}, MemRead, 1'b0);
        check({tag, "_wr"}, MemWrite, 1'b0);
        check({tag, "_addr"}, Address, 32'h0);
        check({tag, "_wdata"}, WriteData, 32'h0);
    endtask

    // One access; expectations derived from byte-lane arithmetic on ref_mem.
    task automatic access(input logic st, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold);
        int          len;
        bit          mis;
        int          ncyc;
        int          rd_cyc;
        int          wr_cyc;
        int          off;
        logic [31:0] old;
        logic [31:0] nw;
        logic [31:0] ld;
        logic [31:0] exp_addr;
        len    = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
        mis    = (len == 2 && a[0]) || (len == 4 && a[1:0] != 2'b00);
        off    = int'(a[1:0]);
        old    = ref_mem[a[7:2]];
        nw     = old;
        ld     = 32'h0;
        rd_cyc = 0;
        wr_cyc = 0;
        if (!mis) begin
            for (int i = 0; i < len; i++) begin
                nw[8*(off+i) +: 8] = wd[8*i +: 8];
                ld[8*i +: 8]       = old[8*(off+i) +: 8];
            end
        end
        if (sx && len < 4 && ld[8*len-1]) ld = ld | (32'hFFFF_FFFF << (8*len));
        if (mis) begin
            ncyc = 1;
        end else if (!st) begin
            ncyc = 2; rd_cyc = 1;
        end else if (len == 4) begin
            ncyc = 2; wr_cyc = 1;
        end else begin
            ncyc = 3; rd_cyc = 1; wr_cyc = 2;
        end
        @(negedge clock);
        check("idle_busy", busy, 1'b0);
        req = 1'b1; is_store = st; size = sz; sign_ext = sx; addr = a; wdata = wd;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clock);
            exp_addr = (c == rd_cyc || c == wr_cyc) ? {a[31:2], 2'b00} : 32'h0;
            if (c == ncyc && !st && !mis) exp_rdata = ld;
            check("busy", busy, 1'b1);
            check("memread", MemRead, c == rd_cyc);
            check("memwrite", MemWrite, c == wr_cyc);
            check("address", Address, exp_addr);
            check("writedata", WriteData, (c == wr_cyc) ? nw : 32'h0);
            check("done", done, c == ncyc);
            check("misaligned", misaligned, (c == ncyc) && mis);
            check("rdata", rdata, exp_rdata);
            if (c == wr_cyc) last_wd = WriteData;
            if (!hold) req = 1'b0;
        end
        if (st && !mis) ref_mem[a[7:2]] = nw;
    endtask

    initial begin
        reset = 1'b1; load_init = 1'b1; req = 1'b0; is_store = 1'b0; size = 2'b00;
        sign_ext = 1'b0; addr = 32'h0; wdata = 32'h0; exp_rdata = 32'h0; last_wd = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
        ref_mem[16] = 32'h8899_AABB;
        ref_mem[8]  = 32'h1122_3344;
        repeat (3) @(negedge clock);
        check("reset_rdata", rdata, 32'h0);
        check_quiet_bus("reset");
        reset = 1'b0; load_init = 1'b0;

        access(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 1'b0);
        check("lb_const", rdata, 32'hFFFF_FF88);
        access(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 1'b0);
        check("lbu_const", rdata, 32'h0000_0088);
        access(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 1'b0);
        check("lhu_const", rdata, 32'h0000_AABB);
        access(1'b0, 2'b10, 1'b1, 32'h40, 32'h0, 1'b0);
        check("lw_const", rdata, 32'h8899_AABB);

        access(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00CC, 1'b0);
        check("sb_wd_const", last_wd, 32'h1122_CC44);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        check("lw_after_sb", rdata, 32'h1122_CC44);
        access(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 1'b0);
        access(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 1'b0);
        check("sh_wd_const", last_wd, 32'hBEEF_3344);
        access(1'b1, 2'b10, 1'b0, 32'h24, 32'hDEAD_BEEF, 1'b0);
        check("sw_wd_const", last_wd, 32'hDEAD_BEEF);
        access(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 1'b0);

        access(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 1'b0);
        access(1'b0, 2'b01, 1'b1, 32'h41, 32'h0, 1'b0);
        check("mis_rdata_kept", rdata, 32'h1122_CC44);

        // Reset during the WRITE cycle of sb 0x21.
        @(negedge clock);
        req = 1'b1; is_store = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h21; wdata = 32'hCC;
        @(negedge clock);
        check("rst_wr_c1_rd", MemRead, 1'b1);
        req = 1'b0;
        @(negedge clock);
        check("rst_wr_c2_wr", MemWrite, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_wr_suppress", MemWrite, 1'b0);
        check("rst_wr_addr", Address, 32'h0);
        check("rst_wr_wdata", WriteData, 32'h0);
        @(negedge clock);
        exp_rdata = 32'h0;
        check("rst_wr_rdata", rdata, 32'h0);
        check_quiet_bus("rst_wr_after");
        reset = 1'b0;
        @(negedge clock);
        check("rst_wr_nodone", done, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        check("rst_wr_mem_kept", rdata, 32'h1122_3344);

        // Reset during LOAD clears rdata.
        @(negedge clock);
        req = 1'b1; is_store = 1'b0; size = 2'b10; addr = 32'h40;
        @(negedge clock);
        check("rst_ld_rd", MemRead, 1'b1);
        req = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_rdata = 32'h0;
        check("rst_ld_rdata", rdata, 32'h0);
        check("rst_ld_nodone", done, 1'b0);

        // Held req gives one access, then a back-to-back second access.
        access(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 1'b1);
        access(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 1'b1);
        @(negedge clock);
        check("hold_idle_busy", busy, 1'b0);
        req = 1'b0;
        @(negedge clock);
        check_quiet_bus("hold_no_requeue");

        for (int n = 0; n < 60; n++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   {24'h0, 8'($urandom)}, $urandom, 1'($urandom_range(0, 1)));
        end
        req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_quiet_bus("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle load/store initiator that sits between the pipeline's MEM stage and the word-organised data memory. It accepts one byte, halfword or word access at a time and checks alignment. It drives the memory's MemRead/MemWrite/Address/WriteData pins and returns sign- or zero-extended load data. The memory is word-only, so sub-word stores run as read-modify-write sequences.

## Interface
- ADDR_W, 32: width of the access address and of the memory Address pin.
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req  in  1  start an access; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word.
- sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  valid only with done; access was rejected.
- rdata  out  32  load result; held until the next load completes.
- MemRead  out  1  to memory read enable.
- MemWrite  out  1  to memory write enable.
- Address  out  ADDR_W  word-aligned address {addr_q[ADDR_W-1:2],2'b00}.
- WriteData  out  32  to memory write data.
- ReadData  in  32  from memory; asynchronous, valid in the same cycle as MemRead.

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, DONE.
- IDLE: on req=1, latch addr, size, is_store, sign_ext and wdata into *_q registers.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠00. It goes to DONE with the error flag set.
  - Otherwise a load goes to LOAD, a word store goes to WRITE, and a byte or half store goes to RMW_READ.
- LOAD: MemRead=1. At the edge, rdata <= lane extracted from ReadData, then extended. Next state DONE.
- RMW_READ: MemRead=1. At the edge, merge_q <= ReadData with the target lane replaced by wdata_q. Next state WRITE.
- WRITE: MemWrite = !reset. WriteData = merge_q for sub-word stores, wdata_q for word stores. Next state DONE.
- DONE: done=1, and misaligned=err flag. Next state IDLE; req is ignored in this state.
- Lane rules (little-endian):
  - byte k = ReadData[8k+7:8k], with k = addr_q[1:0].
  - halfword = ReadData[16h+15:16h], with h = addr_q[1].
  - Sign extension copies the lane MSB.
- Misaligned accesses never assert MemRead or MemWrite, and leave rdata unchanged.
- When neither MemRead nor MemWrite is asserted, Address=0 and WriteData=0. There are no X on the bus.
- req while busy=1 is ignored and not queued. The pipeline must hold req until it sees done.

## Timing
- Reset values: state IDLE, busy 0, done 0, misaligned 0, rdata 0, merge_q 0, MemRead 0, MemWrite 0, Address 0, WriteData 0.
- req accepted at edge T (in IDLE). Cycle counts below are from the cycle after T:
  - lw/lh/lb: LOAD in cycle 1, done in cycle 2.
  - sw: WRITE in cycle 1, done in cycle 2.
  - sh/sb: RMW_READ in cycle 1, WRITE in cycle 2, done in cycle 3.
  - misaligned: done with misaligned=1 in cycle 1.
- A new req is accepted earliest in the cycle after done (back-to-back accesses).
- rdata is updated at the LOAD→DONE edge and is stable while done=1.
- Reset has priority in every state; the next state is IDLE.
  - Reset during WRITE suppresses MemWrite combinationally, so no memory write occurs in that cycle.
  - Reset during LOAD leaves rdata at 0 (reset value).
  - No done pulse is produced for an access aborted by reset.

## Structure
- Shared package/header mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encodings for the five states;
  - a misalignment-check function.
- One combinational sub-module, mem_lane_align, handles:
  - extract + extend (inputs: word, addr[1:0], size, sign_ext);
  - merge (inputs: old word, wdata, addr[1:0], size).
  - It is shared by the LOAD and RMW_READ paths.
- The top holds the FSM, the latch registers, merge_q, rdata, and the output decode.

## Test plan
- Memory word 0x40 = 0x8899AABB.
  - lb 0x43 → rdata 0xFFFFFF88 at cycle 2.
  - lbu 0x43 → 0x00000088.
  - lhu 0x40 → 0x0000AABB.
  - lw 0x40 → 0x8899AABB.
- Word 0x20 = 0x11223344, sb 0x21 with wdata 0x000000CC:
  - MemRead in cycle 1;
  - MemWrite in cycle 2 with Address 0x20 and WriteData 0x1122CC44;
  - done in cycle 3;
  - a following lw 0x20 returns 0x1122CC44.
- sh 0x22 with wdata 0x0000BEEF on 0x11223344 → WriteData 0xBEEF3344.
- sw 0x24 with 0xDEADBEEF → a single MemWrite in cycle 1, done in cycle 2.
- lw 0x42 and lh 0x41 → done+misaligned in cycle 1; MemRead and MemWrite stay 0 throughout; rdata unchanged.
- Reset in the WRITE cycle of sb 0x21 → memory still 0x11223344; next cycle all outputs at reset values; no done.
- req held high through busy → exactly one access. A second req in the cycle after done is accepted immediately.
